sram_like_slave: RTL and testbench
==================================

SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, backing-store depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter QDEPTH, default 4, maximum outstanding accepted requests (power of 2).
REQ-003 SHALL have parameter LAT, default 2, minimum cycles from acceptance to data_ok (1..7).
REQ-004 SHALL have ports clk, in, 1, the single clock; resetn, in, 1, synchronous active-low reset.
REQ-005 SHALL have ports req, in, 1, request valid; wr, in, 1, 1 = write.
REQ-006 SHALL have ports size, in, 2, access size (informational); wstrb, in, 4, byte write enables.
REQ-007 SHALL have ports addr, in, 32, byte address; wdata, in, 32, write data.
REQ-008 SHALL have ports addr_ok, out, 1, request accepted; data_ok, out, 1, response valid; rdata, out, 32, read data.
REQ-009 SHALL have port outstanding, out, $clog2(QDEPTH)+1, current queue occupancy.

Function
REQ-010 Acceptance SHALL occur in every cycle with req && addr_ok; addr_ok = req && !full (&& !stall when REQ-022 applies), combinational.
REQ-011 addr_ok SHALL NOT depend on a same-cycle data_ok pop; when full, no request is accepted even if the head retires.
REQ-012 Word index SHALL be addr[$clog2(MEM_WORDS)+1:2]; higher bits ignored (aliasing wrap); addr[1:0] ignored.
REQ-013 An accepted write SHALL update the bytes selected by wstrb at the accepting clock edge; wstrb=0 writes nothing.
REQ-014 An accepted read SHALL capture the word at the accepting edge, including a write accepted in an earlier cycle.
REQ-015 Each accepted request SHALL push one entry {is_wr, data, age}; age resets to 0 and increments per cycle, saturating at LAT.
REQ-016 data_ok SHALL be 1 for exactly one cycle per request, in acceptance order, when the head entry has age == LAT; the head pops on that cycle.
REQ-017 With no backpressure, data_ok SHALL assert exactly LAT cycles after the accept edge; back-to-back accepts yield back-to-back data_ok.
REQ-018 rdata SHALL equal the head entry data while data_ok=1 for reads, 32'h0 for writes, and 32'h0 when data_ok=0.
REQ-019 Push and pop in the same cycle SHALL leave occupancy unchanged; pointers SHALL carry one extra wrap bit; full = (MSB differ, rest equal), empty = equal.
REQ-020 outstanding SHALL equal pushes minus pops since reset, range 0..QDEPTH.

Reset
REQ-021 When resetn=0 at a clock edge: queue emptied, ages cleared, outstanding=0, data_ok=0, rdata=0, addr_ok=0; memory contents retained; in-flight requests discarded and never answered.

Configuration
REQ-022 With SRAM_SLAVE_RAND_STALL_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), reset seed 16'hACE1, advanced every cycle; stall = lfsr[0], forcing addr_ok=0 that cycle.
REQ-023 Without SRAM_SLAVE_RAND_STALL_EN: no LFSR logic; addr_ok is blocked only by full.

Structure
REQ-024 Package sram_slave_pkg SHALL hold the queue entry typedef, default parameter constants and the LFSR seed/taps.
REQ-025 Backing store SHALL be sub-module sram_slave_mem (sync write with byte enables, async read); queue, ages and handshake logic reside in sram_like_slave.

Verification
REQ-026 Write addr=0x10 wdata=0xDEADBEEF wstrb=4'hF, then read 0x10 -> read data_ok at LAT cycles after its accept, rdata=0xDEADBEEF.
REQ-027 Write 0x20 data 0x11223344 strb F, then write 0xAABBCCDD strb 4'b0101, read 0x20 -> rdata=0x11BB33DD.
REQ-028 Hold req=1 five cycles with LAT=2, QDEPTH=4, no stall -> 5 accepts, data_ok on 5 consecutive cycles starting 2 cycles after first accept, in order.
REQ-029 LAT=7, QDEPTH=4, req held -> addr_ok drops after 4 accepts, outstanding=4, resumes the cycle after the first pop.
REQ-030 Read 0x0 and read 0x1000 (MEM_WORDS=1024) after writing 0x5A5A5A5A to 0x0 -> both return 0x5A5A5A5A.
REQ-031 Assert resetn=0 with 3 outstanding -> next cycle outstanding=0, data_ok=0 for 10 cycles without req; prior written data still readable.

Source files
------------

// File: rtl/sram_slave_pkg.sv
// Shared types and defaults for the SRAM-like slave model.
// Holds the queue entry layout, default parameters and LFSR seed/taps.
package sram_slave_pkg;

    localparam int DEF_MEM_WORDS = 1024;
    localparam int DEF_QDEPTH    = 4;
    localparam int DEF_LAT       = 2;

    // Fibonacci taps 16,14,13,11 -> bit positions 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] data;
        logic [2:0]  age;
    } q_entry_t;

endpackage

// File: rtl/sram_slave_mem.sv
// Word-wide backing store: sync byte-enabled write, async read.
// Ports: clk, we, wstrb[3:0], idx (word index), wdata[31:0], rdata[31:0].
module sram_slave_mem
    import sram_slave_pkg::*;
#(
    parameter int WORDS = DEF_MEM_WORDS
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [3:0]               wstrb,
    input  logic [$clog2(WORDS)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [WORDS];

    // No reset: contents survive resetn.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like slave: addr_ok/data_ok handshake, in-order response queue
// with fixed minimum latency LAT and up to QDEPTH outstanding requests.
// Ports: clk, resetn (sync, active low), req, wr, size, wstrb, addr,
// wdata in; addr_ok, data_ok, rdata, outstanding out.
// Option: define SRAM_SLAVE_RAND_STALL_EN for LFSR-driven accept stalls.
module sram_like_slave
    import sram_slave_pkg::*;
#(
    parameter int MEM_WORDS = DEF_MEM_WORDS,
    parameter int QDEPTH    = DEF_QDEPTH,
    parameter int LAT       = DEF_LAT
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     req,
    input  logic                     wr,
    input  logic [1:0]               size,
    input  logic [3:0]               wstrb,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic                     addr_ok,
    output logic                     data_ok,
    output logic [31:0]              rdata,
    output logic [$clog2(QDEPTH):0]  outstanding
);

    localparam int AW    = $clog2(QDEPTH);
    localparam int PW    = AW + 1;
    localparam int IW    = (AW > 0) ? AW : 1;
    localparam int SLOTS = 1 << IW;
    localparam int MW    = $clog2(MEM_WORDS);

    localparam logic [2:0]    LAT3     = 3'(LAT);
    localparam logic [PW-1:0] FULL_XOR = PW'(1) << AW;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    q_entry_t      q [SLOTS];

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          stall;
    logic [IW-1:0] widx;
    logic [IW-1:0] ridx;
    logic [MW-1:0] word_idx;
    logic [31:0]   mem_rdata;
    logic          unused;

    assign unused = ^{size, addr[31:MW+2], addr[1:0]};

`ifdef SRAM_SLAVE_RAND_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // With QDEPTH=1 the slot index aliases the wrap bit; two slots
    // exist but at most one is ever live.
    assign widx = wptr[IW-1:0];
    assign ridx = rptr[IW-1:0];

    assign full  = (wptr ^ rptr) == FULL_XOR;
    assign empty = wptr == rptr;

    // Occupancy before this cycle's pop decides acceptance.
    assign addr_ok = req && !full && !stall && resetn;
    assign push    = addr_ok;

    assign data_ok = !empty && (q[ridx].age == LAT3);
    assign pop     = data_ok;

    assign rdata = (data_ok && !q[ridx].is_wr) ? q[ridx].data : 32'h0;

    assign outstanding = wptr - rptr;

    assign word_idx = addr[MW+1:2];

    sram_slave_mem #(
        .WORDS(MEM_WORDS)
    ) u_mem (
        .clk  (clk),
        .we   (push && wr),
        .wstrb(wstrb),
        .idx  (word_idx),
        .wdata(wdata),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                q[i] <= '0;
            end
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            for (int i = 0; i < SLOTS; i++) begin
                if (push && (widx == IW'(i))) begin
                    q[i] <= '{is_wr: wr, data: mem_rdata, age: 3'd0};
                end else if (q[i].age != LAT3) begin
                    q[i].age <= q[i].age + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: LAT=2 and LAT=7 instances,
// transaction-level model plus directed literal checks.
module tb_sram_like_slave;

    logic        clk;
    logic        resetn;
    logic        req [2];
    logic        wr [2];
    logic [1:0]  size [2];
    logic [3:0]  wstrb [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        addr_ok [2];
    logic        data_ok [2];
    logic [31:0] rdata [2];
    logic [2:0]  outstanding [2];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        bit        wr;
        bit [31:0] data;
        int        due;
    } exp_t;

    exp_t      mq [2][$];
    bit [31:0] mm [2][1024];
    int        lat [2] = '{2, 7};

    int        acc_log [2][$];
    int        dok_log [2][$];
    bit [31:0] rd_log [2][$];

    bit [31:0] t4a [5] = '{32'h10, 32'h20, 32'h0, 32'h10, 32'h20};
    bit [31:0] t4d [5] = '{32'hDEADBEEF, 32'h11BB33DD, 32'h5A5A5A5A,
                           32'hDEADBEEF, 32'h11BB33DD};

    sram_like_slave #(.MEM_WORDS(1024), .QDEPTH(4), .LAT(2)) u0 (
        .clk(clk), .resetn(resetn), .req(req[0]), .wr(wr[0]),
        .size(size[0]), .wstrb(wstrb[0]), .addr(addr[0]),
        .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]),
        .rdata(rdata[0]), .outstanding(outstanding[0])
    );

    sram_like_slave #(.MEM_WORDS(1024), .QDEPTH(4), .LAT(7)) u1 (
        .clk(clk), .resetn(resetn), .req(req[1]), .wr(wr[1]),
        .size(size[1]), .wstrb(wstrb[1]), .addr(addr[1]),
        .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]),
        .rdata(rdata[1]), .outstanding(outstanding[1])
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int k, bit [31:0] act, bit [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
        else
            passed++;
    endtask

    // Model: a response is due LAT edges after its accept edge, i.e.
    // LAT+1 negedges after the negedge at which it was accepted.
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            bit        edok;
            bit [31:0] erd;
            bit        eaok;
            int        n;
            int        wi;
            n    = mq[k].size();
            edok = (n > 0) && (cyc >= mq[k][0].due);
            erd  = (edok && !mq[k][0].wr) ? mq[k][0].data : 32'h0;
            eaok = req[k] && (n < 4);
            if (resetn) begin
                chk("addr_ok", k, 32'(addr_ok[k]), 32'(eaok));
                chk("data_ok", k, 32'(data_ok[k]), 32'(edok));
                chk("rdata", k, rdata[k], erd);
                chk("outstanding", k, 32'(outstanding[k]), n);
                if (req[k] && addr_ok[k]) acc_log[k].push_back(cyc);
                if (data_ok[k]) begin
                    dok_log[k].push_back(cyc);
                    rd_log[k].push_back(rdata[k]);
                end
                if (edok) void'(mq[k].pop_front());
                if (eaok) begin
                    exp_t e;
                    wi = int'(addr[k][11:2]);
                    e.wr   = wr[k];
                    e.data = mm[k][wi];
                    e.due  = cyc + lat[k] + 1;
                    if (wr[k]) begin
                        for (int b = 0; b < 4; b++)
                            if (wstrb[k][b])
                                mm[k][wi][b*8 +: 8] = wdata[k][b*8 +: 8];
                    end
                    mq[k].push_back(e);
                end
            end else begin
                mq[k].delete();
            end
        end
    end

    task automatic issue(int k, bit w, bit [31:0] a, bit [31:0] d,
                         bit [3:0] s);
        req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d; wstrb[k] = s;
        @(posedge clk); #1;
        req[k] = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int k = 0; k < 2; k++) begin
            acc_log[k].delete();
            dok_log[k].delete();
            rd_log[k].delete();
        end
    endtask

    initial begin
        clk = 1'b0;
        resetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; wr[k] = 1'b0; size[k] = 2'd2;
            wstrb[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
        end
        idle(3);
        resetn = 1'b1;
        idle(2);

        // write then read, latency pinned
        clr();
        issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        issue(0, 0, 32'h10, 32'h0, 4'h0);
        idle(6);
        chk("t1_count", 0, dok_log[0].size(), 2);
        if (dok_log[0].size() >= 2 && acc_log[0].size() >= 2) begin
            chk("t1_wr_rdata", 0, rd_log[0][0], 32'h0);
            chk("t1_rdata", 0, rd_log[0][1], 32'hDEADBEEF);
            chk("t1_lat", 0, dok_log[0][1] - acc_log[0][1], 3);
        end

        // wstrb=0 leaves memory alone
        clr();
        issue(0, 1, 32'h10, 32'h0BADF00D, 4'h0);
        issue(0, 0, 32'h10, 32'h0, 4'h0);
        idle(6);
        if (rd_log[0].size() >= 2)
            chk("t_strb0", 0, rd_log[0][1], 32'hDEADBEEF);
        else
            chk("t_strb0_count", 0, rd_log[0].size(), 2);

        // partial byte write
        clr();
        issue(0, 1, 32'h20, 32'h11223344, 4'hF);
        issue(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
        issue(0, 0, 32'h20, 32'h0, 4'h0);
        idle(6);
        if (rd_log[0].size() >= 3)
            chk("t2_rdata", 0, rd_log[0][2], 32'h11BB33DD);
        else
            chk("t2_count", 0, rd_log[0].size(), 3);

        // address aliasing
        clr();
        issue(0, 1, 32'h0, 32'h5A5A5A5A, 4'hF);
        issue(0, 0, 32'h0, 32'h0, 4'h0);
        issue(0, 0, 32'h1000, 32'h0, 4'h0);
        idle(6);
        if (rd_log[0].size() >= 3) begin
            chk("t3_rd0", 0, rd_log[0][1], 32'h5A5A5A5A);
            chk("t3_rd1000", 0, rd_log[0][2], 32'h5A5A5A5A);
        end else
            chk("t3_count", 0, rd_log[0].size(), 3);

        // five back-to-back reads
        clr();
        for (int i = 0; i < 5; i++) issue(0, 0, t4a[i], 32'h0, 4'h0);
        idle(8);
        chk("t4_acc", 0, acc_log[0].size(), 5);
        chk("t4_dok", 0, dok_log[0].size(), 5);
        if (acc_log[0].size() == 5 && dok_log[0].size() == 5) begin
            chk("t4_acc_span", 0, acc_log[0][4] - acc_log[0][0], 4);
            chk("t4_first", 0, dok_log[0][0] - acc_log[0][0], 3);
            chk("t4_dok_span", 0, dok_log[0][4] - dok_log[0][0], 4);
            for (int i = 0; i < 5; i++)
                chk("t4_order", 0, rd_log[0][i], t4d[i]);
        end

        // LAT=7: fill queue, stall, resume after first pop
        issue(1, 1, 32'h40, 32'h12345678, 4'hF);
        idle(10);
        clr();
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h40; wstrb[1] = 4'h0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t5_full_aok", 1, 32'(addr_ok[1]), 32'h0);
        chk("t5_full_occ", 1, 32'(outstanding[1]), 4);
        repeat (7) @(posedge clk);
        #1;
        req[1] = 1'b0;
        idle(20);
        if (acc_log[1].size() >= 5 && dok_log[1].size() >= 1) begin
            chk("t5_resume", 1, acc_log[1][4] - acc_log[1][0], 9);
            chk("t5_first", 1, dok_log[1][0] - acc_log[1][0], 8);
            chk("t5_rdata", 1, rd_log[1][0], 32'h12345678);
        end else
            chk("t5_count", 1, acc_log[1].size(), 5);

        // reset with three outstanding
        clr();
        issue(0, 0, 32'h10, 32'h0, 4'h0);
        issue(0, 0, 32'h20, 32'h0, 4'h0);
        issue(0, 0, 32'h0, 32'h0, 4'h0);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("t6_occ", 0, 32'(outstanding[0]), 0);
        idle(10);
        chk("t6_no_dok", 0, dok_log[0].size(), 0);
        issue(0, 0, 32'h20, 32'h0, 4'h0);
        idle(6);
        if (rd_log[0].size() == 1)
            chk("t6_retained", 0, rd_log[0][0], 32'h11BB33DD);
        else
            chk("t6_count", 0, rd_log[0].size(), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
